// File: rtl/log_ops_pkg.sv
// rtl/log_ops_pkg.sv - shared constants and types for the logical-operator block
package log_ops_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Registered result bundle, MSB first: u, v, x, y, z
    typedef struct packed {
        logic u;
        logic v;
        logic x;
        logic y;
        logic z;
    } log_res_t;

    localparam logic     RST_U   = 1'b0;
    localparam logic     RST_V   = 1'b0;
    localparam logic     RST_X   = 1'b0;
    localparam logic     RST_Y   = 1'b0;
    localparam logic     RST_Z   = 1'b0;
    localparam log_res_t RST_RES = '{u: RST_U, v: RST_V, x: RST_X, y: RST_Y, z: RST_Z};

endpackage

// File: rtl/log_truth.sv
// rtl/log_truth.sv - reduces an operand to its 4-state truth value
module log_truth
    import log_ops_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] op_i,
    output logic             truth_o
);

    // Reduction OR: any 1 gives 1, all 0 gives 0, otherwise x
    assign truth_o = |op_i;

endmodule

// File: rtl/log_operators.sv
// rtl/log_operators.sv - registered logical AND/OR/NOT/mixed/NOR of three operands
module log_operators
    import log_ops_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             u,
    output logic             v,
    output logic             x,
    output logic             y,
    output logic             z
);

    logic     ta;
    logic     tb;
    logic     tc;
    log_res_t res_d;
    log_res_t res_q;

    log_truth #(.WIDTH(WIDTH)) u_truth_a (.op_i(a), .truth_o(ta));
    log_truth #(.WIDTH(WIDTH)) u_truth_b (.op_i(b), .truth_o(tb));
    log_truth #(.WIDTH(WIDTH)) u_truth_c (.op_i(c), .truth_o(tc));

    // Logical network over the truth bits; logical operators keep x semantics
    always_comb begin
        res_d   = RST_RES;
        res_d.u = ta && tb;
        res_d.v = tb || tc;
        res_d.x = !ta;
        res_d.y = (ta || tb) && !tc;
        res_d.z = !(ta || tb || tc);
    end

    // Output register, cleared asynchronously while rst_n is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= RST_RES;
        end else begin
            res_q <= res_d;
        end
    end

    assign u = res_q.u;
    assign v = res_q.v;
    assign x = res_q.x;
    assign y = res_q.y;
    assign z = res_q.z;

endmodule

// File: tb/tb_log_operators.sv
// tb/tb_log_operators.sv - scoreboard bench for log_operators
module tb_log_operators;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         u;
    logic         v;
    logic         x;
    logic         y;
    logic         z;

    typedef struct {
        string      tag;
        logic [4:0] exp;
        logic [4:0] mask;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks;
    int        n_fails;

    log_operators #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .u     (u),
        .v     (v),
        .x     (x),
        .y     (y),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {u, v, x, y, z};
    endfunction

    task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got uvxyz=%b expected %b", tag, obs, exp);
        end
    endtask

    // Independent model: truth value as "operand differs from zero"
    function automatic logic [4:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [W-1:0] mc);
        logic pa, pb, pc;
        pa = (ma != '0);
        pb = (mb != '0);
        pc = (mc != '0);
        return {pa & pb, pb | pc, ~pa, (pa | pb) & ~pc, ~(pa | pb | pc)};
    endfunction

    task automatic drive(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [4:0] exp, input logic [4:0] mask);
        sb_entry_t e;
        a = va;
        b = vb;
        c = vc;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    // Called on the falling edge after the capturing rising edge
    task automatic pop_check();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected >=1");
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, outs() & e.mask, e.exp & e.mask);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb, rc;
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        c = '0;

        repeat (2) @(negedge clk);
        check_eq("reset_state", outs(), 5'b00000);
        rst_n = 1'b1;

        // Directed vectors: each driven on a falling edge, checked one cycle later
        drive("vec1", 4'b1000, 4'b1100, 4'b0000, 5'b11010, 5'b11111);
        @(negedge clk); pop_check();
        drive("vec2", 4'b0000, 4'b1010, 4'b0100, 5'b01100, 5'b11111);
        @(negedge clk); pop_check();
        // y depends on x-valued c and is left unchecked; the rest short-circuit
        drive("vec3_xprop", 4'b0010, 4'b1010, 4'b00xx, 5'b11000, 5'b11101);
        @(negedge clk); pop_check();
        drive("vec4_zero", 4'b0000, 4'b0000, 4'b0000, 5'b00101, 5'b11111);
        @(negedge clk); pop_check();
        drive("vec6_logical", 4'b1000, 4'b0100, 4'b0010, 5'b11000, 5'b11111);
        @(negedge clk); pop_check();

        // Reset between edges clears outputs at once and discards the pending result
        a = 4'b1000;
        b = 4'b1100;
        c = 4'b0000;
        @(posedge clk);
        #2;
        check_eq("pre_reset_vec1", outs(), 5'b11010);
        a = 4'b0000;
        b = 4'b0000;
        c = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_clear", outs(), 5'b00000);
        a = 4'b1000;
        b = 4'b1100;
        c = 4'b0000;
        @(posedge clk);
        #2;
        check_eq("reset_hold", outs(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("release_no_edge", outs(), 5'b00000);
        drive("vec1_after_reset", 4'b1000, 4'b1100, 4'b0000, 5'b11010, 5'b11111);
        @(negedge clk); pop_check();

        // Sparse random vectors so zero operands appear often
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom) & W'($urandom);
            rb = W'($urandom) & W'($urandom);
            rc = W'($urandom) & W'($urandom) & W'($urandom);
            drive($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc), 5'b11111);
            @(negedge clk); pop_check();
        end

        check_eq("scoreboard_drained", 5'(sb_q.size()), 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
